// File: rtl/btn_sw_dev_in_pkg.sv
// Shared constants for the switch/button input peripheral: register map,
// event bit positions and the writable-bit mask helper.
package btn_sw_dev_in_pkg;

    typedef enum logic [1:0] {
        ADDR_SW     = 2'd0,
        ADDR_BTN    = 2'd1,
        ADDR_STATUS = 2'd2,
        ADDR_MASK   = 2'd3
    } reg_addr_e;

    localparam int PRESS_LSB   = 0;
    localparam int RELEASE_LSB = 16;

    // Bits of STATUS/MASK that physically exist for a given button count.
    function automatic logic [31:0] evt_mask(input int btn_w, input bit with_release);
        logic [31:0] m;
        m = ((32'd1 << btn_w) - 32'd1) << PRESS_LSB;
        if (with_release) begin
            m = m | (m << RELEASE_LSB);
        end
        return m;
    endfunction

endpackage

// File: rtl/btn_sw_dev_in_if.sv
// Register-window bus between the CPU side and the switch/button peripheral.
interface btn_sw_dev_in_if;
    logic        io_rd;
    logic        io_we;
    logic [1:0]  io_addr;
    logic [31:0] Peripheral_in;
    logic [31:0] io_rdata;
    logic        io_rdy;

    modport master (
        output io_rd, io_we, io_addr, Peripheral_in,
        input  io_rdata, io_rdy
    );

    modport slave (
        input  io_rd, io_we, io_addr, Peripheral_in,
        output io_rdata, io_rdy
    );
endinterface

// File: rtl/btn_sw_dev_in_debounce_bit.sv
// One pad bit: 2-flop synchroniser followed by a saturating stability counter.
// rise/fall are combinational and coincide with the edge that updates stable.
module debounce_bit #(
    parameter int DB_LIMIT = 500000,
    parameter int CNT_W    = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_LIMIT - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // Counter only runs while the synchronised value disagrees with stable.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise   = stable_d & ~stable_q;
    assign fall   = ~stable_d & stable_q;

endmodule

// File: rtl/btn_sw_dev_in.sv
// Switch/button input device: debounced levels, sticky press status, mask and irq.
// Define BTN_RELEASE_EVT_EN to also latch release events into STATUS[31:16].
module btn_sw_dev_in
    import btn_sw_dev_in_pkg::*;
#(
    parameter int SW_W     = 8,
    parameter int BTN_W    = 5,
    parameter int DB_LIMIT = 500000,
    parameter int CNT_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   sw_in,
    input  logic [BTN_W-1:0]  btn_in,
    btn_sw_dev_in_if.slave    bus,
    output logic              btn_irq
);

    localparam int NB = SW_W + BTN_W;
`ifdef BTN_RELEASE_EVT_EN
    localparam logic [31:0] EVT_MASK = evt_mask(BTN_W, 1'b1);
`else
    localparam logic [31:0] EVT_MASK = evt_mask(BTN_W, 1'b0);
`endif

    logic [NB-1:0] raw_all, stable_all, rise_all, fall_all;
    logic [SW_W-1:0]  sw_stable;
    logic [BTN_W-1:0] btn_stable, btn_rise;
    logic             unused_edges;

    assign raw_all = {btn_in, sw_in};

    for (genvar i = 0; i < NB; i++) begin : g_db
        debounce_bit #(
            .DB_LIMIT (DB_LIMIT),
            .CNT_W    (CNT_W)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw_all[i]),
            .stable (stable_all[i]),
            .rise   (rise_all[i]),
            .fall   (fall_all[i])
        );
    end

    assign sw_stable  = stable_all[SW_W-1:0];
    assign btn_stable = stable_all[NB-1:SW_W];
    assign btn_rise   = rise_all[NB-1:SW_W];

    logic [31:0] status_q, status_d;
    logic [31:0] mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdy_q, rdy_d;
    logic        irq_q, irq_d;
    logic [31:0] evt_set;
    logic        wr_status, wr_mask;

`ifdef BTN_RELEASE_EVT_EN
    logic [BTN_W-1:0] btn_fall;
    assign btn_fall     = fall_all[NB-1:SW_W];
    assign unused_edges = ^{rise_all[SW_W-1:0], fall_all[SW_W-1:0]};
`else
    assign unused_edges = ^{rise_all[SW_W-1:0], fall_all};
`endif

    always_comb begin
        evt_set = '0;
        evt_set[PRESS_LSB +: BTN_W] = btn_rise;
`ifdef BTN_RELEASE_EVT_EN
        evt_set[RELEASE_LSB +: BTN_W] = btn_fall;
`endif
        wr_status = bus.io_we && (bus.io_addr == ADDR_STATUS);
        wr_mask   = bus.io_we && (bus.io_addr == ADDR_MASK);

        // Clear first, then OR in new events so a same-cycle event survives W1C.
        status_d = status_q;
        if (wr_status) begin
            status_d = status_q & ~(bus.Peripheral_in & EVT_MASK);
        end
        status_d = status_d | evt_set;

        mask_d = mask_q;
        if (wr_mask) begin
            mask_d = bus.Peripheral_in & EVT_MASK;
        end

        // Read mux sees pre-update register values.
        rdata_d = rdata_q;
        if (bus.io_rd) begin
            case (bus.io_addr)
                ADDR_SW:     rdata_d = 32'(sw_stable);
                ADDR_BTN:    rdata_d = 32'(btn_stable);
                ADDR_STATUS: rdata_d = status_q;
                ADDR_MASK:   rdata_d = mask_q;
                default:     rdata_d = rdata_q;
            endcase
        end
        rdy_d = bus.io_rd;
        irq_d = |(status_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            status_q <= '0;
            mask_q   <= '0;
            rdata_q  <= '0;
            rdy_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            mask_q   <= mask_d;
            rdata_q  <= rdata_d;
            rdy_q    <= rdy_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.io_rdata = rdata_q;
    assign bus.io_rdy   = rdy_q;
    assign btn_irq      = irq_q;

endmodule

// File: tb/tb_btn_sw_dev_in.sv
// Scoreboard bench for btn_sw_dev_in: a window-based debounce/status model feeds
// an expected-read queue that an independent negedge monitor drains.
module tb_btn_sw_dev_in;

    localparam int SW_W  = 8;
    localparam int BTN_W = 5;
    localparam int DB    = 4;
    localparam int NB    = SW_W + BTN_W;
`ifdef BTN_RELEASE_EVT_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif
    localparam logic [31:0] VALID = REL ? 32'h001F_001F : 32'h0000_001F;

    logic             clk;
    logic             rst;
    logic [SW_W-1:0]  sw_in;
    logic [BTN_W-1:0] btn_in;
    logic             btn_irq;

    btn_sw_dev_in_if bus_if ();

    btn_sw_dev_in #(
        .SW_W     (SW_W),
        .BTN_W    (BTN_W),
        .DB_LIMIT (DB),
        .CNT_W    (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in),
        .btn_in  (btn_in),
        .bus     (bus_if.slave),
        .btn_irq (btn_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: pad history by edge index, debounced levels, registers.
    logic [NB-1:0] hist [64];
    int            ecnt = 100;
    logic [NB-1:0] m_stable;
    logic [31:0]   m_status, m_mask;
    bit            exp_rdy, exp_irq, mon_en;
    logic [31:0]   exp_q [$];
    logic [1:0]    addr_q [$];

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_stable[SW_W-1:0]);
            2'd1:    return 32'(m_stable[NB-1:SW_W]);
            2'd2:    return m_status;
            default: return m_mask;
        endcase
    endfunction

    // A debounced bit flips once the synchronised pad (2 edges late) has
    // disagreed with it for DB consecutive edges.
    task automatic tick();
        logic [NB-1:0] c_pad, new_st;
        logic          c_rst, c_rd, c_we;
        logic [1:0]    c_addr;
        logic [31:0]   c_wdata, evt;
        logic [BTN_W-1:0] ob, nb;
        bit flip;
        c_pad = {btn_in, sw_in};
        c_rst = rst; c_rd = bus_if.io_rd; c_we = bus_if.io_we;
        c_addr = bus_if.io_addr; c_wdata = bus_if.Peripheral_in;
        @(posedge clk);
        if (!c_rst) begin
            m_stable = '0; m_status = '0; m_mask = '0;
            exp_rdy = 1'b0; exp_irq = 1'b0;
            hist[ecnt % 64] = '0;
            hist[(ecnt - 1) % 64] = '0;
        end else begin
            hist[ecnt % 64] = c_pad;
            if (c_rd) begin
                exp_q.push_back(model_read(c_addr));
                addr_q.push_back(c_addr);
            end
            exp_rdy = c_rd;
            exp_irq = |(m_status & m_mask);
            new_st = m_stable;
            for (int b = 0; b < NB; b++) begin
                flip = 1'b1;
                for (int j = 2; j <= DB + 1; j++) begin
                    if (hist[(ecnt - j) % 64][b] == m_stable[b]) flip = 1'b0;
                end
                if (flip) new_st[b] = ~m_stable[b];
            end
            ob = m_stable[NB-1:SW_W];
            nb = new_st[NB-1:SW_W];
            evt = 32'(nb & ~ob);
            if (REL) evt = evt | (32'(ob & ~nb) << 16);
            if (c_we && c_addr == 2'd2) m_status = m_status & ~(c_wdata & VALID);
            m_status = m_status | evt;
            if (c_we && c_addr == 2'd3) m_mask = c_wdata & VALID;
            m_stable = new_st;
        end
        ecnt++;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_read(input logic [1:0] a);
        bus_if.io_rd = 1'b1; bus_if.io_addr = a;
        tick();
        bus_if.io_rd = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.io_we = 1'b1; bus_if.io_addr = a; bus_if.Peripheral_in = d;
        tick();
        bus_if.io_we = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        logic [1:0]  a;
        if (mon_en) begin
            checks++;
            if (bus_if.io_rdy !== exp_rdy) begin
                errors++;
                $display("FAIL io_rdy t=%0t got %b want %b", $time, bus_if.io_rdy, exp_rdy);
            end
            checks++;
            if (btn_irq !== exp_irq) begin
                errors++;
                $display("FAIL btn_irq t=%0t got %b want %b", $time, btn_irq, exp_irq);
            end
            if (bus_if.io_rdy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rdy t=%0t rdata %h with no read pending", $time, bus_if.io_rdata);
                end else begin
                    e = exp_q.pop_front();
                    a = addr_q.pop_front();
                    checks++;
                    if (bus_if.io_rdata !== e) begin
                        errors++;
                        $display("FAIL rdata addr%0d t=%0t got %h want %h", a, $time, bus_if.io_rdata, e);
                    end
                end
            end
        end
    end

    initial begin
        int hold;
        for (int i = 0; i < 64; i++) hist[i] = '0;
        m_stable = '0; m_status = '0; m_mask = '0;
        exp_rdy = 1'b0; exp_irq = 1'b0; mon_en = 1'b0;
        rst = 1'b0; sw_in = 8'hFF; btn_in = '0;
        bus_if.io_rd = 1'b0; bus_if.io_we = 1'b0;
        bus_if.io_addr = 2'd0; bus_if.Peripheral_in = '0;

        // Reset with switches high; outputs must be zero throughout.
        for (int i = 0; i < 3; i++) begin
            tick();
            mon_en = 1'b1;
            checks++;
            if (bus_if.io_rdata !== 32'd0) begin
                errors++;
                $display("FAIL reset_rdata got %h want 00000000", bus_if.io_rdata);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 9; i++) do_read(2'd0);

        // Glitch of DB-1 cycles on button 0.
        btn_in = 5'b00001; ticks(DB - 1);
        btn_in = '0;       ticks(8);
        do_read(2'd1); do_read(2'd2);

        // Press with mask enabled.
        do_write(2'd3, 32'h0000_0001);
        btn_in = 5'b00001; ticks(10);
        do_read(2'd2);

        // W1C landing on the same edge as a fresh press of bit 0.
        btn_in = '0;       ticks(8);
        btn_in = 5'b00001; ticks(5);
        do_write(2'd2, 32'h0000_0001);
        ticks(2);
        do_read(2'd2);
        do_write(2'd2, 32'h0000_0001);
        ticks(2);
        do_read(2'd2);

        // Back-to-back reads including a concurrent write.
        bus_if.io_rd = 1'b1;
        bus_if.io_addr = 2'd1; tick();
        bus_if.io_addr = 2'd2; tick();
        bus_if.io_addr = 2'd3; bus_if.io_we = 1'b1; bus_if.Peripheral_in = 32'hFFFF_FFFF; tick();
        bus_if.io_rd = 1'b0; bus_if.io_we = 1'b0;
        tick();
        do_read(2'd3);

`ifdef BTN_RELEASE_EVT_EN
        btn_in = '0; ticks(8);
        do_write(2'd2, 32'hFFFF_FFFF);
        do_write(2'd3, 32'h0004_0004);
        btn_in = 5'b00100; ticks(8);
        btn_in = '0;       ticks(8);
        do_read(2'd2);
        do_write(2'd2, 32'h0004_0000);
        do_read(2'd2);
`endif

        // Randomised pads and bus traffic, with one reset in the middle.
        hold = 0;
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                btn_in = 5'($urandom_range(0, 31));
                sw_in  = 8'($urandom);
                hold   = $urandom_range(1, 9);
            end
            hold--;
            rst = (c >= 400 && c < 402) ? 1'b0 : 1'b1;
            bus_if.io_rd   = ($urandom_range(0, 2) == 0);
            bus_if.io_we   = ($urandom_range(0, 4) == 0);
            bus_if.io_addr = 2'($urandom_range(0, 3));
            bus_if.Peripheral_in = $urandom;
            tick();
        end
        rst = 1'b1;
        bus_if.io_rd = 1'b0; bus_if.io_we = 1'b0;
        ticks(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d reads outstanding want 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
